// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Two-requester round-robin sequencer around a shared
//               combinational ALU. Runs single-cycle ops in one EXEC cycle
//               and expands shift-by-1 ALU codes into shift-by-N by
//               iterating the ALU N cycles. Results are returned on a
//               valid/ready response channel tagged with the requester id.
//               Optional macro ALU_SEQ_BACK2BACK_EN lets the arbiter accept
//               a new request in the same cycle a response is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   rr_q;      // preferred requester when both are valid
    logic [3:0]             ctrl_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic                   id_q;
    logic [DATA_WIDTH-1:0]  acc_q;     // running shift value
    logic [SHAMT_WIDTH-1:0] cnt_q;     // shift iterations still to run
    logic [DATA_WIDTH-1:0]  result_q;

    logic                   grant_vld_d;
    logic                   grant_id_d;
    logic                   accept_en_d;
    logic                   accept_d;
    logic [3:0]             sel_ctrl_d;
    logic [DATA_WIDTH-1:0]  sel_a_d;
    logic [DATA_WIDTH-1:0]  sel_b_d;
    logic                   sel_is_shift_d;

    // Arbitration: lone requester wins, otherwise the round-robin pointer decides
    always_comb begin
        grant_vld_d = req0_valid | req1_valid;
        grant_id_d  = (req0_valid & req1_valid) ? rr_q : req1_valid;
`ifdef ALU_SEQ_BACK2BACK_EN
        accept_en_d = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
`else
        accept_en_d = (state_q == ST_IDLE);
`endif
        req0_ready     = accept_en_d & grant_vld_d & ~grant_id_d;
        req1_ready     = accept_en_d & grant_vld_d &  grant_id_d;
        accept_d       = req0_ready | req1_ready;
        sel_ctrl_d     = grant_id_d ? req1_ctrl : req0_ctrl;
        sel_a_d        = grant_id_d ? req1_a    : req0_a;
        sel_b_d        = grant_id_d ? req1_b    : req0_b;
        sel_is_shift_d = (sel_ctrl_d == 4'b0101) || (sel_ctrl_d == 4'b0110) ||
                         (sel_ctrl_d == 4'b0111);
    end

    // Sequencer FSM: accept, execute or iterate shifts, then hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if ((state_q == ST_RESP) && rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                    // A new accept overrides the return to IDLE above
                    if (accept_d) begin
                        ctrl_q <= sel_ctrl_d;
                        a_q    <= sel_a_d;
                        b_q    <= sel_b_d;
                        id_q   <= grant_id_d;
                        rr_q   <= ~grant_id_d;
                        if (sel_is_shift_d) begin
                            cnt_q <= sel_b_d[SHAMT_WIDTH-1:0];
                            if (sel_b_d[SHAMT_WIDTH-1:0] == '0) begin
                                result_q <= sel_a_d;
                                state_q  <= ST_RESP;
                            end else begin
                                acc_q   <= sel_a_d;
                                state_q <= ST_SHIFT;
                            end
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    state_q  <= ST_RESP;
                end
                ST_SHIFT: begin
                    acc_q <= alu_result;
                    cnt_q <= cnt_q - SHAMT_WIDTH'(1);
                    // Last iteration: this ALU output is the final value
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        result_q <= alu_result;
                        state_q  <= ST_RESP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ALU drive and response outputs decoded from the registered state
    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_control   = 4'b0000;
        if (state_q == ST_EXEC) begin
            alu_operand_a = a_q;
            alu_operand_b = b_q;
            alu_control   = ctrl_q;
        end else if (state_q == ST_SHIFT) begin
            alu_operand_a = acc_q;
            alu_operand_b = b_q;
            alu_control   = ctrl_q;
        end
        rsp_valid  = (state_q == ST_RESP);
        rsp_id     = rsp_valid & id_q;
        rsp_result = rsp_valid ? result_q : '0;
        busy       = (state_q != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Scoreboard bench for alu_seq_ctrl with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl, alu_control;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_result, alu_operand_a, alu_operand_b, alu_result;

    alu_seq_ctrl #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_control(alu_control), .alu_result(alu_result), .busy(busy)
    );

    // Reference ALU with shift-by-1 operations
    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            4'b0000: alu_result = alu_operand_a + alu_operand_b;
            4'b0001: alu_result = alu_operand_a - alu_operand_b;
            4'b0010: alu_result = alu_operand_a & alu_operand_b;
            4'b0011: alu_result = alu_operand_a | alu_operand_b;
            4'b0100: alu_result = alu_operand_a ^ alu_operand_b;
            4'b0101: alu_result = {alu_operand_a[30:0], 1'b0};
            4'b0110: alu_result = {1'b0, alu_operand_a[31:1]};
            4'b0111: alu_result = {alu_operand_a[31], alu_operand_a[31:1]};
            4'b1000: alu_result = {31'h0, $signed(alu_operand_a) < $signed(alu_operand_b)};
            4'b1001: alu_result = {31'h0, alu_operand_a < alu_operand_b};
            default: alu_result = 32'h0;
        endcase
    end

    always #5 clk = ~clk;

    int cyc = 0;
    int sll_cnt = 0;
    int drive_cnt = 0;
    int checks = 0;
    int passes = 0;
    bit in_rsp = 1'b0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (alu_control == 4'b0101) sll_cnt++;
        if (|{alu_operand_a, alu_operand_b, alu_control}) drive_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: latency at response start, id/result at handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready && req1_ready) check("ready_onehot", 32'd1, 32'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    if (!in_rsp) begin
                        in_rsp = 1'b1;
                        check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                    end
                    if (rsp_ready) begin
                        check("rsp_id", {31'h0, rsp_id}, {31'h0, exp_q[0].id});
                        check("rsp_result", rsp_result, exp_q[0].res);
                        void'(exp_q.pop_front());
                        in_rsp = 1'b0;
                    end
                end
            end
        end
    end

    // Present one op from requester id; call at a falling edge
    task automatic issue(input bit id, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat);
        bit done = 1'b0;
        if (id == 1'b0) begin
            req0_ctrl = ctrl; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_ctrl = ctrl; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                exp_q.push_back('{id, res, cyc, lat});
                done = 1'b1;
            end
            @(negedge clk);
        end
        // Scramble operands after accept; the DUT must ignore them
        if (id == 1'b0) begin
            req0_valid = 1'b0; req0_a = 32'hA5A5_5A5A; req0_b = 32'h5A5A_A5A5;
        end else begin
            req1_valid = 1'b0; req1_a = 32'hA5A5_5A5A; req1_b = 32'h5A5A_A5A5;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_rsp_id"}, {31'h0, rsp_id}, 32'h0);
        check({tag, "_rsp_result"}, rsp_result, 32'h0);
        check({tag, "_alu_a"}, alu_operand_a, 32'h0);
        check({tag, "_alu_b"}, alu_operand_b, 32'h0);
        check({tag, "_alu_ctrl"}, {28'h0, alu_control}, 32'h0);
        check({tag, "_ready"}, {30'h0, req1_ready, req0_ready}, 32'h0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_ctrl = 4'h0; req0_a = 32'h0; req0_b = 32'h0;
        req1_valid = 1'b0; req1_ctrl = 4'h0; req1_a = 32'h0; req1_b = 32'h0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD: busy through RESP, idle at T+3
        issue(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 2);
        check("busy_T1", {31'h0, busy}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("busy_T3", {31'h0, busy}, 32'h0);
        wait_drain();

        // Both valid from reset: req0 first, then alternation
        apply_reset();
        fork
            issue(1'b0, 4'b0001, 32'd10, 32'd3, 32'd7, 2);
            issue(1'b1, 4'b0100, 32'hF0, 32'hFF, 32'h0F, 2);
        join
        wait_drain();
        fork
            issue(1'b0, 4'b0000, 32'd2, 32'd3, 32'd5, 2);
            issue(1'b1, 4'b0011, 32'h0F, 32'hF0, 32'hFF, 2);
        join
        wait_drain();

        // Shift by 5: five iterations on the ALU
        base = sll_cnt;
        issue(1'b1, 4'b0101, 32'd1, 32'd5, 32'd32, 6);
        wait_drain();
        check("sll_iterations", 32'(sll_cnt - base), 32'd5);

        // Shift by 0: result straight from operand A, ALU untouched
        base = drive_cnt;
        issue(1'b1, 4'b0101, 32'd1, 32'd0, 32'd1, 1);
        wait_drain();
        check("shift0_alu_idle", 32'(drive_cnt - base), 32'd0);

        issue(1'b0, 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
        issue(1'b1, 4'b0110, 32'h8000_0000, 32'h25, 32'h0400_0000, 6);
        issue(1'b0, 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 2);
        issue(1'b1, 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0, 2);
        issue(1'b0, 4'b1010, 32'd9, 32'd9, 32'd0, 2);
        wait_drain();

        // Backpressure: response held, both requesters stalled
        rsp_ready = 1'b0;
        issue(1'b0, 4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 2);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("hold_ready", {30'h0, req1_ready, req0_ready}, 32'h0);
            check("hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold_result", rsp_result, 32'h0F00_0F00);
            check("hold_id", {31'h0, rsp_id}, 32'h0);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        fork
            issue(1'b0, 4'b0000, 32'd1, 32'd1, 32'd2, 2);
            issue(1'b1, 4'b0001, 32'd5, 32'd2, 32'd3, 2);
        join
        wait_drain();

        // Reset mid-shift with 3 iterations left
        issue(1'b0, 4'b0101, 32'd1, 32'd8, 32'd256, 9);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        in_rsp = 1'b0;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_reset_idle", {31'h0, busy}, 32'h0);
        fork
            issue(1'b1, 4'b0000, 32'd1, 32'd1, 32'd2, 2);
            issue(1'b0, 4'b0100, 32'd6, 32'd3, 32'd5, 2);
        join
        wait_drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
